// File: rtl/rr_arb_mux.sv
// rr_arb_mux: CHANNELS-way round-robin arbiter feeding a one-entry registered output slot.
// Optional macro RR_ARB_MUX_SRC_EN adds out_src, the channel index of the beat in out_data.
module rr_arb_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
`ifdef RR_ARB_MUX_SRC_EN
    output logic [SELW-1:0]           out_src,
`endif
    input  logic                      out_ready
);

    localparam int unsigned NCH = CHANNELS;

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
`ifdef RR_ARB_MUX_SRC_EN
    logic [SELW-1:0]  out_src_q, out_src_d;
`endif

    logic [WIDTH-1:0] chan_data [CHANNELS];
    logic             load;
    logic             grant_found;
    logic [SELW-1:0]  grant_idx;
    logic [SELW-1:0]  ptr_next;

    always_comb begin : unpack_channels
        for (int unsigned i = 0; i < NCH; i++) begin
            chan_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Search from ptr upwards with wraparound; the first valid channel wins.
    always_comb begin : grant_search
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!grant_found && in_valid[SELW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = SELW'(idx);
            end
        end
    end

    always_comb begin : ptr_advance
        if (32'(grant_idx) == NCH - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + 1'b1;
        end
    end

    assign load = !out_valid_q || out_ready;

    // rst_n gates in_ready directly so no source sees a handshake while reset is held.
    always_comb begin : ready_decode
        in_ready = '0;
        if (rst_n && load && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin : next_state
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_MUX_SRC_EN
        out_src_d   = out_src_q;
`endif
        if (load) begin
            out_valid_d = grant_found;
            if (grant_found) begin
                out_data_d = chan_data[grant_idx];
                ptr_d      = ptr_next;
`ifdef RR_ARB_MUX_SRC_EN
                out_src_d  = grant_idx;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ptr_q       <= '0;
`ifdef RR_ARB_MUX_SRC_EN
            out_src_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
`ifdef RR_ARB_MUX_SRC_EN
            out_src_q   <= out_src_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef RR_ARB_MUX_SRC_EN
    assign out_src   = out_src_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: a 4-channel and a 3-channel instance driven with directed vectors.
module tb_rr_arb_mux;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4*W-1:0] in_data4;
    logic [3:0]     in_valid4, in_ready4;
    logic [W-1:0]   out_data4;
    logic           out_valid4, out_ready4;

    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3, in_ready3;
    logic [W-1:0]   out_data3;
    logic           out_valid3, out_ready3;

`ifdef RR_ARB_MUX_SRC_EN
    logic [1:0] out_src4, out_src3;
`endif

    rr_arb_mux #(.WIDTH(W), .CHANNELS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4),
`ifdef RR_ARB_MUX_SRC_EN
        .out_src(out_src4),
`endif
        .out_ready(out_ready4)
    );

    rr_arb_mux #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3),
`ifdef RR_ARB_MUX_SRC_EN
        .out_src(out_src3),
`endif
        .out_ready(out_ready3)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] src;
    } beat_t;

    beat_t q4[$];
    beat_t q3[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push4(input logic [7:0] d, input logic [1:0] s);
        beat_t b;
        b.data = d;
        b.src  = s;
        q4.push_back(b);
    endtask

    task automatic push3(input logic [7:0] d, input logic [1:0] s);
        beat_t b;
        b.data = d;
        b.src  = s;
        q3.push_back(b);
    endtask

    // Monitors: every beat the consumer accepts must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beat4_unexpected: got %0h expected no beat at %0t", out_data4, $time);
            end else begin
                beat_t e;
                e = q4.pop_front();
                check("beat4_data", 32'(out_data4), 32'(e.data));
`ifdef RR_ARB_MUX_SRC_EN
                check("beat4_src", 32'(out_src4), 32'(e.src));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beat3_unexpected: got %0h expected no beat at %0t", out_data3, $time);
            end else begin
                beat_t e;
                e = q3.pop_front();
                check("beat3_data", 32'(out_data3), 32'(e.data));
`ifdef RR_ARB_MUX_SRC_EN
                check("beat3_src", 32'(out_src3), 32'(e.src));
`endif
            end
        end
    end

    // Drive after the edge; channel i carries base+i.
    task automatic drive4(input logic [3:0] v, input logic [7:0] base, input logic ordy);
        @(posedge clk);
        #1;
        in_valid4  = v;
        out_ready4 = ordy;
        for (int i = 0; i < 4; i++) in_data4[i*W +: W] = base + 8'(i);
        #1;
    endtask

    task automatic drive3(input logic [2:0] v, input logic [7:0] base, input logic ordy);
        @(posedge clk);
        #1;
        in_valid3  = v;
        out_ready3 = ordy;
        for (int i = 0; i < 3; i++) in_data3[i*W +: W] = base + 8'(i);
        #1;
    endtask

    initial begin
        in_valid4  = 4'hF;
        in_data4   = 32'hDEADBEEF;
        out_ready4 = 1'b0;
        in_valid3  = '0;
        in_data3   = '0;
        out_ready3 = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid4), 0);
        check("rst_out_data", 32'(out_data4), 0);
        check("rst_in_ready", 32'(in_ready4), 0);
        in_valid4 = '0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Single source on ch2 from ptr=0
        drive4(4'b0100, 8'hA3, 1'b1);
        check("s2_in_ready", 32'(in_ready4), 32'h4);
        push4(8'hA5, 2'd2);
        drive4(4'b0000, 8'h00, 1'b1);
        check("s2_out_valid", 32'(out_valid4), 1);
        check("s2_out_data", 32'(out_data4), 32'hA5);
        check("s2_idle_ready", 32'(in_ready4), 0);
        drive4(4'b0000, 8'h00, 1'b1);
        check("s2_drained_valid", 32'(out_valid4), 0);
        check("s2_data_holds", 32'(out_data4), 32'hA5);

        // Backpressure; ptr=3 so ch3 wins first
        drive4(4'b1111, 8'h40, 1'b0);
        check("s4_grant_ch3", 32'(in_ready4), 32'h8);
        push4(8'h43, 2'd3);
        for (int k = 0; k < 3; k++) begin
            drive4(4'b1111, 8'(8'h50 + k * 16), 1'b0);
            check("s4_stall_ready", 32'(in_ready4), 0);
            check("s4_stall_valid", 32'(out_valid4), 1);
            check("s4_stall_data", 32'(out_data4), 32'h43);
        end
        drive4(4'b1111, 8'h80, 1'b1);
        check("s4_refill_ready", 32'(in_ready4), 32'h1);
        check("s4_refill_old_data", 32'(out_data4), 32'h43);
        push4(8'h80, 2'd0);
        drive4(4'b0000, 8'h00, 1'b1);
        check("s4_refill_valid", 32'(out_valid4), 1);
        check("s4_refill_data", 32'(out_data4), 32'h80);

        // Reset mid-stream with a buffered beat
        drive4(4'b0010, 8'h90, 1'b0);
        check("s1_grant_ch1", 32'(in_ready4), 32'h2);
        push4(8'h91, 2'd1);
        drive4(4'b0000, 8'h00, 1'b0);
        check("s1_buffered_data", 32'(out_data4), 32'h91);
        #2;
        rst_n     = 1'b0;
        in_valid4 = 4'hF;
        #1;
        check("s1_async_valid", 32'(out_valid4), 0);
        check("s1_async_data", 32'(out_data4), 0);
        check("s1_async_ready", 32'(in_ready4), 0);
        void'(q4.pop_back());
        in_valid4  = '0;
        out_ready4 = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // All valid, full throughput; ptr restarts at 0
        for (int k = 0; k < 8; k++) begin
            drive4(4'b1111, 8'(8'h08 + k * 16), 1'b1);
            check("s3_in_ready", 32'(in_ready4), 32'(1 << (k % 4)));
            push4(8'(8'h08 + k * 16 + (k % 4)), 2'(k % 4));
            if (k > 0) check("s3_no_bubble", 32'(out_valid4), 1);
        end
        drive4(4'b0000, 8'h00, 1'b1);
        check("s3_last_valid", 32'(out_valid4), 1);
        check("s3_last_data", 32'(out_data4), 32'h7B);
        drive4(4'b0000, 8'h00, 1'b1);
        check("s3_idle_valid", 32'(out_valid4), 0);

        // Three channels: wraparound behaviour
        drive3(3'b010, 8'hB0, 1'b1);
        check("s5_grant_ch1", 32'(in_ready3), 32'h2);
        push3(8'hB1, 2'd1);
        drive3(3'b001, 8'hC0, 1'b1);
        check("s5_wrap_ch0", 32'(in_ready3), 32'h1);
        push3(8'hC0, 2'd0);
        drive3(3'b111, 8'hD0, 1'b1);
        check("s5_ptr1_ch1", 32'(in_ready3), 32'h2);
        push3(8'hD1, 2'd1);
        drive3(3'b111, 8'hE0, 1'b1);
        check("s5_ptr2_ch2", 32'(in_ready3), 32'h4);
        push3(8'hE2, 2'd2);
        drive3(3'b111, 8'hF0, 1'b1);
        check("s5_ptr0_ch0", 32'(in_ready3), 32'h1);
        push3(8'hF0, 2'd0);
        drive3(3'b000, 8'h00, 1'b1);
        check("s5_last_data", 32'(out_data3), 32'hF0);
        drive3(3'b000, 8'h00, 1'b1);
        check("s5_idle_valid", 32'(out_valid3), 0);

        @(posedge clk);
        #1;
        check("q4_drained", 32'(q4.size()), 0);
        check("q3_drained", 32'(q3.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
